// File: rtl/fclass_pkg.sv
// Shared types and constants for the FCLASS classifier.
package fclass_pkg;

    localparam int unsigned CLASS_W = 10;

    // One-hot class bit positions
    localparam int unsigned CLS_NEG_INF  = 0;
    localparam int unsigned CLS_NEG_NORM = 1;
    localparam int unsigned CLS_NEG_SUB  = 2;
    localparam int unsigned CLS_NEG_ZERO = 3;
    localparam int unsigned CLS_POS_ZERO = 4;
    localparam int unsigned CLS_POS_SUB  = 5;
    localparam int unsigned CLS_POS_NORM = 6;
    localparam int unsigned CLS_POS_INF  = 7;
    localparam int unsigned CLS_SNAN     = 8;
    localparam int unsigned CLS_QNAN     = 9;

    // Decoded operand flags, carried from S1 into the S2 encoder
    typedef struct packed {
        logic sign;
        logic exp_zero;
        logic exp_ones;
        logic frac_zero;
        logic quiet;
        logic unboxed;
    } flags_t;

endpackage : fclass_pkg

// File: rtl/fclass_decode.sv
// Combinational FCLASS decode: operand -> flags, and flags -> one-hot class mask.
module fclass_decode
    import fclass_pkg::*;
#(
    parameter int unsigned EXPWIDTH = 8,
    parameter int unsigned SIGWIDTH = 24,
    parameter int unsigned FLEN     = 64
) (
    input  logic [FLEN-1:0]    in_data,
    input  flags_t             flags,
    output flags_t             flags_c,
    output logic [CLASS_W-1:0] mask_c
);

    localparam int unsigned W = EXPWIDTH + SIGWIDTH;

    logic boxed_ok;

    // NaN-box check only exists when the register is wider than the format
    generate
        if (FLEN > W) begin : g_box
            assign boxed_ok = &in_data[FLEN-1:W];
        end else begin : g_nobox
            assign boxed_ok = 1'b1;
        end
    endgenerate

    // Extract sign/exponent/fraction properties of the operand
    always_comb begin
        flags_c           = '0;
        flags_c.sign      = in_data[W-1];
        flags_c.exp_zero  = ~|in_data[W-2:SIGWIDTH-1];
        flags_c.exp_ones  = &in_data[W-2:SIGWIDTH-1];
        flags_c.frac_zero = ~|in_data[SIGWIDTH-2:0];
        flags_c.quiet     = in_data[SIGWIDTH-2];
        flags_c.unboxed   = ~boxed_ok;
    end

    // Encode flags into exactly one class bit; a broken NaN-box reads as qNaN
    always_comb begin
        mask_c = '0;
        if (flags.unboxed) begin
            mask_c[CLS_QNAN] = 1'b1;
        end else if (flags.exp_ones) begin
            if (flags.frac_zero) begin
                if (flags.sign) mask_c[CLS_NEG_INF] = 1'b1;
                else            mask_c[CLS_POS_INF] = 1'b1;
            end else begin
                if (flags.quiet) mask_c[CLS_QNAN] = 1'b1;
                else             mask_c[CLS_SNAN] = 1'b1;
            end
        end else if (flags.exp_zero) begin
            if (flags.frac_zero) begin
                if (flags.sign) mask_c[CLS_NEG_ZERO] = 1'b1;
                else            mask_c[CLS_POS_ZERO] = 1'b1;
            end else begin
                if (flags.sign) mask_c[CLS_NEG_SUB] = 1'b1;
                else            mask_c[CLS_POS_SUB] = 1'b1;
            end
        end else begin
            if (flags.sign) mask_c[CLS_NEG_NORM] = 1'b1;
            else            mask_c[CLS_POS_NORM] = 1'b1;
        end
    end

endmodule : fclass_decode

// File: rtl/fclass_pipe.sv
// Two-stage FCLASS pipeline with valid/ready handshake and sticky seen-class mask.
module fclass_pipe
    import fclass_pkg::*;
#(
    parameter int unsigned EXPWIDTH = 8,
    parameter int unsigned SIGWIDTH = 24,
    parameter int unsigned FLEN     = 64,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TAG_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLEN-1:0]    in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_class,
    output logic [TAG_W-1:0]   out_tag,
    input  logic               seen_clr,
    output logic [CLASS_W-1:0] seen_mask
);

    logic               s1_valid;
    flags_t             s1_flags;
    logic [TAG_W-1:0]   s1_tag;
    logic               s2_valid;
    logic [CLASS_W-1:0] s2_class;
    logic [TAG_W-1:0]   s2_tag;

    flags_t             dec_flags_c;
    logic [CLASS_W-1:0] dec_mask_c;
    logic               s1_en;
    logic               s2_en;
    logic               out_hs;

    fclass_decode #(
        .EXPWIDTH (EXPWIDTH),
        .SIGWIDTH (SIGWIDTH),
        .FLEN     (FLEN)
    ) u_decode (
        .in_data  (in_data),
        .flags    (s1_flags),
        .flags_c  (dec_flags_c),
        .mask_c   (dec_mask_c)
    );

    // Stage advance: a stage moves when it is empty or its successor moves
    assign s2_en    = ~s2_valid | out_ready;
    assign s1_en    = ~s1_valid | s2_en;
    assign in_ready = s1_en;
    assign out_hs   = s2_valid & out_ready;

    assign out_valid = s2_valid;
    assign out_class = XLEN'(s2_class);
    assign out_tag   = s2_tag;

    // S1: capture decoded flags and tag on an input handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_flags <= '0;
            s1_tag   <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_flags <= dec_flags_c;
                s1_tag   <= in_tag;
            end
        end
    end

    // S2: capture encoded class mask and tag; holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_class <= '0;
            s2_tag   <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_class <= dec_mask_c;
                s2_tag   <= s1_tag;
            end
        end
    end

    // Sticky class history; clear wipes old content but keeps a coincident delivery
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_mask <= '0;
        end else if (seen_clr) begin
            seen_mask <= out_hs ? s2_class : '0;
        end else if (out_hs) begin
            seen_mask <= seen_mask | s2_class;
        end
    end

endmodule : fclass_pipe

// File: tb/tb_fclass_pipe.sv
// Directed self-checking bench for fclass_pipe (default and binary64 parameters).
module tb_fclass_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, seen_clr;
    logic [63:0] in_data;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_class;
    logic [9:0]  seen_mask;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_seen_clr;
    logic [63:0] a_in_data, a_out_class;
    logic [4:0]  a_in_tag, a_out_tag;
    logic [9:0]  a_seen_mask;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fclass_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_tag   (out_tag),
        .seen_clr  (seen_clr),
        .seen_mask (seen_mask)
    );

    fclass_pipe #(
        .EXPWIDTH (11),
        .SIGWIDTH (53),
        .FLEN     (64),
        .XLEN     (64),
        .TAG_W    (5)
    ) dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_tag    (a_in_tag),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_class (a_out_class),
        .out_tag   (a_out_tag),
        .seen_clr  (a_seen_clr),
        .seen_mask (a_seen_mask)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    typedef struct {
        logic [63:0] data;
        logic [9:0]  cls;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    // Send one operand at the next negedge and drop valid afterwards
    task automatic send(input logic [63:0] d, input logic [4:0] t);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          got_n;
        logic [4:0]  got_tags[3];

        vecs[0]  = '{64'hFFFFFFFF_3F800000, 10'h040};
        vecs[1]  = '{64'hFFFFFFFF_FF800000, 10'h001};
        vecs[2]  = '{64'hFFFFFFFF_80000001, 10'h004};
        vecs[3]  = '{64'hFFFFFFFF_00000000, 10'h010};
        vecs[4]  = '{64'hFFFFFFFF_80000000, 10'h008};
        vecs[5]  = '{64'hFFFFFFFF_7F800000, 10'h080};
        vecs[6]  = '{64'hFFFFFFFF_BF800000, 10'h002};
        vecs[7]  = '{64'hFFFFFFFF_00000001, 10'h020};
        vecs[8]  = '{64'hFFFFFFFF_7F800001, 10'h100};
        vecs[9]  = '{64'hFFFFFFFF_7FC00000, 10'h200};
        vecs[10] = '{64'h00000000_3F800000, 10'h200};
        vecs[11] = '{64'h7FFFFFFF_00000000, 10'h200};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1; seen_clr = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1'b1; a_seen_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_class", 64'(out_class), 64'd0);
        check("rst_seen",      64'(seen_mask), 64'd0);
        rst = 1'b0;

        // Back-to-back vectors, result expected two cycles after each handshake
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check($sformatf("vec%0d_valid", i - 2), 64'(out_valid), 64'd1);
                check($sformatf("vec%0d_class", i - 2), 64'(out_class), 64'(vecs[i-2].cls));
                check($sformatf("vec%0d_tag", i - 2),   64'(out_tag),   64'(i - 2));
            end
            in_valid = (i < NV);
            in_data  = (i < NV) ? vecs[i].data : 64'd0;
            in_tag   = 5'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: two accepts fill the pipe, third waits
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hFFFFFFFF_3F800000; in_tag = 5'd1;
        check("bp_ready1", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_data = 64'hFFFFFFFF_FF800000; in_tag = 5'd2;
        check("bp_ready2", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_data = 64'hFFFFFFFF_80000000; in_tag = 5'd3;
        check("bp_ready3", 64'(in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_stall_ready", 64'(in_ready),  64'd0);
            check("bp_stall_tag",   64'(out_tag),   64'd1);
            check("bp_stall_class", 64'(out_class), 64'h040);
        end
        out_ready = 1'b1;
        got_n = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid && out_ready) begin
                if (got_n < 3) got_tags[got_n] = out_tag;
                got_n++;
            end
            if (k == 1) in_valid = 1'b0;
        end
        check("bp_count", 64'(got_n), 64'd3);
        check("bp_tag0", 64'(got_tags[0]), 64'd1);
        check("bp_tag1", 64'(got_tags[1]), 64'd2);
        check("bp_tag2", 64'(got_tags[2]), 64'd3);

        // seen_mask accumulate, clear, and clear coincident with delivery
        @(negedge clk); seen_clr = 1'b1;
        @(negedge clk); seen_clr = 1'b0;
        check("seen_pre_clr", 64'(seen_mask), 64'd0);
        send(64'hFFFFFFFF_3F800000, 5'd4);
        send(64'hFFFFFFFF_7F800001, 5'd5);
        repeat (2) @(negedge clk);
        check("seen_acc", 64'(seen_mask), 64'h140);
        seen_clr = 1'b1;
        @(negedge clk); seen_clr = 1'b0;
        check("seen_clr", 64'(seen_mask), 64'h000);
        send(64'hFFFFFFFF_3F800000, 5'd6);
        repeat (2) @(negedge clk);
        check("seen_refill", 64'(seen_mask), 64'h040);
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'hFFFFFFFF_80000000; in_tag = 5'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("seen_coinc_valid", 64'(out_valid), 64'd1);
        seen_clr = 1'b1;
        @(negedge clk);
        seen_clr = 1'b0;
        check("seen_coinc", 64'(seen_mask), 64'h008);

        // Reset with both stages full
        out_ready = 1'b0;
        send(64'hFFFFFFFF_3F800000, 5'd8);
        send(64'hFFFFFFFF_FF800000, 5'd9);
        check("rstmid_full", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_seen",  64'(seen_mask), 64'd0);
        check("rstmid_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstmid_no_stale", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'hFFFFFFFF_7F800000; in_tag = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstmid_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("rstmid_after_valid", 64'(out_valid), 64'd1);
        check("rstmid_after_class", 64'(out_class), 64'h080);
        check("rstmid_after_tag",   64'(out_tag),   64'd10);

        // binary64 instance, no NaN-boxing, 64-bit result
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 64'hFFF0000000000000; a_in_tag = 5'd1;
        @(negedge clk);
        a_in_data = 64'h7FF4000000000000; a_in_tag = 5'd2;
        @(negedge clk);
        a_in_valid = 1'b0;
        check("d64_valid0", 64'(a_out_valid), 64'd1);
        check("d64_class0", a_out_class, 64'h001);
        @(negedge clk);
        check("d64_class1", a_out_class, 64'h100);
        check("d64_tag1",   64'(a_out_tag), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fclass_pipe
